dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data RAM between two requesters:
  - Port A: the pipeline memory stage.
  - Port B: a loader/debug DMA port.
- Fixed priority: A over B. A starvation guard forces a B grant after a bounded wait.
- Sits between the memory stage and the ram instance. Owns the RAM address, write-data and write-enable muxes, and routes read data back to the owner.
- Produces the pipeline stall when A loses arbitration.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles B may be requested-but-denied before B is forced a grant (valid range 1..15).
- ADDR_W, 32: address width on both ports and the RAM side.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_req  in  1  memory-stage access request
- a_we  in  1  memory-stage write (1) / read (0)
- a_addr  in  ADDR_W  memory-stage address (alu result)
- a_wdata  in  32  memory-stage store data
- a_gnt  out  1  A access accepted this cycle
- a_stall  out  1  a_req & ~a_gnt; freezes the pipeline
- a_rvalid  out  1  read data for A valid this cycle
- a_rdata  out  32  read data for A
- b_req  in  1  DMA request
- b_we  in  1  DMA write / read
- b_addr  in  ADDR_W  DMA address
- b_wdata  in  32  DMA write data
- b_gnt  out  1  B access accepted this cycle
- b_rvalid  out  1  read data for B valid
- b_rdata  out  32  read data for B
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM read/write address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data; synchronous, 1-cycle latency after address

Behaviour:
- Reset (rst_n=0, asynchronous):
  - starve_cnt=0, rd_owner=NONE.
  - a_rvalid=b_rvalid=0.
  - a_gnt, b_gnt, ram_we are forced 0 while rst_n=0.
  - a_rdata/b_rdata=0 while rd_owner=NONE.
- Grant decision is combinational, in the request cycle:
  - force_b = b_req & (starve_cnt == STARVE_LIMIT).
  - b_gnt = b_req & (~a_req | force_b).
  - a_gnt = a_req & ~b_gnt.
  - Exactly one or zero grants per cycle.
- RAM mux:
  - Granted port drives ram_addr, ram_wdata and ram_we (= port we & gnt).
  - With no grant: ram_we=0, ram_addr=a_addr, ram_wdata=0.
- starve_cnt, updated per edge:
  - If b_req & ~b_gnt: increment, saturating at STARVE_LIMIT.
  - If b_gnt or ~b_req: clear to 0.
- Read-return owner register rd_owner ∈ {NONE, A, B}:
  - Next value is A if a_gnt & ~a_we; B if b_gnt & ~b_we; else NONE.
  - a_rvalid = (rd_owner==A), a_rdata = ram_rdata when rd_owner==A, else 0. Same for B.
- Read latency: 1 cycle from grant to rvalid. Back-to-back reads are pipelined at full rate, 1 per cycle.
- Write latency: write commits at the grant edge. No response pulse.
- Ownership on forced B: A is stalled exactly 1 cycle. starve_cnt then clears, so A regains priority the next cycle.
- A request held through a stall must keep addr/we/wdata stable. The arbiter does not register requests.
- Reset mid-read: a pending rvalid is discarded (rd_owner → NONE). No spurious rvalid after rst_n rises.
- Simultaneous A write and B read to the same address: only the granted one proceeds. There is no hazard inside the arbiter.

Optional Feature:
- Macro DMEM_ARB_PERF_EN.
- When defined, adds output ports:
  - conflict_cnt [31:0]: counts cycles with a_req & b_req.
  - stall_cnt [31:0]: counts cycles with a_stall=1.
  - Both reset to 0, wrap at 2^32, increment on the same edges as the state.
- When undefined, the ports and counters are absent. All other behaviour is identical.

Test Plan:
- A-only read, a_addr=0x10, RAM holds 0xDEADBEEF at 0x10:
  - a_gnt=1, a_stall=0 same cycle.
  - Next cycle a_rvalid=1, a_rdata=0xDEADBEEF, b_rvalid=0.
- B-only write, b_addr=0x20, b_wdata=0x12345678:
  - b_gnt=1, ram_we=1, ram_addr=0x20.
  - A later A read of 0x20 returns 0x12345678.
- Starvation, a_req and b_req held continuously with STARVE_LIMIT=4:
  - b_gnt=0 for 4 cycles, then b_gnt=1 and a_stall=1 on cycle 5.
  - Cycle 6 a_gnt=1. Pattern repeats with period 5.
- Back-to-back reads, A at 0x0 then B at 0x4 on consecutive cycles:
  - a_rvalid in cycle 2, b_rvalid in cycle 3.
  - Each carries its own address's data; no cross-routing.
- Reset mid-read:
  - A read granted, rst_n pulled low before the next edge.
  - a_rvalid stays 0 and rd_owner=NONE; after release, the first A read behaves normally.
- With DMEM_ARB_PERF_EN, 10 cycles of both requesting:
  - conflict_cnt=10, stall_cnt=2 (forced B grants at cycles 5 and 10).

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: port A (memory stage) over port B (DMA), with a starvation guard for B.
// Optional `DMEM_ARB_PERF_EN adds conflict_cnt / stall_cnt performance counters.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]       conflict_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } rd_owner_t;

  rd_owner_t  rd_owner, rd_owner_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic       force_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner   <= OWN_NONE;
      starve_cnt <= '0;
    end else begin
      rd_owner   <= rd_owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Grants are qualified by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    force_b = b_req & (starve_cnt == LIMIT);
    b_gnt   = rst_n & b_req & (~a_req | force_b);
    a_gnt   = rst_n & a_req & ~b_gnt;
    a_stall = a_req & ~a_gnt;

    ram_we    = 1'b0;
    ram_addr  = a_addr;
    ram_wdata = '0;
    if (b_gnt) begin
      ram_we    = b_we;
      ram_addr  = b_addr;
      ram_wdata = b_wdata;
    end else if (a_gnt) begin
      ram_we    = a_we;
      ram_addr  = a_addr;
      ram_wdata = a_wdata;
    end

    starve_nxt = '0;
    if (b_req && !b_gnt)
      starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;

    rd_owner_nxt = OWN_NONE;
    if (a_gnt && !a_we)
      rd_owner_nxt = OWN_A;
    else if (b_gnt && !b_we)
      rd_owner_nxt = OWN_B;
  end

  always_comb begin
    a_rvalid = (rd_owner == OWN_A);
    b_rvalid = (rd_owner == OWN_B);
    a_rdata  = a_rvalid ? ram_rdata : '0;
    b_rdata  = b_rvalid ? ram_rdata : '0;
  end

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (a_req && b_req) conflict_cnt <= conflict_cnt + 32'd1;
      if (a_stall)        stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
